// File: rtl/sdpb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdpb_pkg
//  Description : Shared definitions for the multi-bank SDP frame/line buffer:
//                a constant clog2 helper, read-latency encodings and the
//                bank-control state record.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package sdpb_pkg;

    // Read-latency encodings
    localparam int RL_BYPASS = 1;   // registered RAM output only
    localparam int RL_PIPE   = 2;   // extra output register after the RAM

    // Bank-state fields are sized for up to 256 banks; the top level masks
    // the pointers down to the configured bank count.
    localparam int SDPB_PTR_W = 8;
    localparam int SDPB_CNT_W = SDPB_PTR_W + 1;

    typedef struct packed {
        logic [SDPB_PTR_W-1:0] wr_ptr;
        logic [SDPB_PTR_W-1:0] rd_ptr;
        logic [SDPB_CNT_W-1:0] banks_full;
    } bank_state_t;

    // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage : sdpb_pkg
`default_nettype wire

// File: rtl/sdpb_bank_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdpb_bank_buffer_if
//  Description : Write/read handshake bundle of the bank buffer.
//                master = client side (capture writer + matrix reader),
//                slave  = the buffer itself.
//  Signals     : wr_en/wr_addr/wr_data/wr_be/wr_commit, wr_ready, wr_drop,
//                rd_en/rd_addr/rd_release, rd_avail, rd_data, rd_dvalid,
//                banks_full
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdpb_bank_buffer_if
    import sdpb_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int DEPTH     = 128,
    parameter int NUM_BANKS = 2
);
    localparam int ADDR_W = clog2(DEPTH);
    localparam int CNT_W  = clog2(NUM_BANKS) + 1;
    localparam int BE_W   = DATA_W / 8;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
    logic              wr_commit;
    logic              wr_ready;
    logic              wr_drop;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_release;
    logic              rd_avail;
    logic [DATA_W-1:0] rd_data;
    logic              rd_dvalid;
    logic [CNT_W-1:0]  banks_full;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, wr_commit,
        output rd_en, rd_addr, rd_release,
        input  wr_ready, wr_drop, rd_avail, rd_data, rd_dvalid, banks_full
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, wr_commit,
        input  rd_en, rd_addr, rd_release,
        output wr_ready, wr_drop, rd_avail, rd_data, rd_dvalid, banks_full
    );

endinterface : sdpb_bank_buffer_if
`default_nettype wire

// File: rtl/sdpb_bank_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sdpb_ram
//  Description : Inferable simple-dual-port RAM, byte-enabled write port,
//                registered read port and optional output register. Shaped
//                to map onto Gowin SDPB block RAM (output latch/register
//                with synchronous reset).
//  Ports       : clk, reset         - clock, sync active-high reset (outputs)
//                wr_en_i, wr_addr_i, wr_data_i, wr_be_i - write port
//                rd_en_i, rd_addr_i - read port
//                rd_data_o          - read data (holds between reads)
//  Revision    : 1.0 - initial release
// ============================================================================
module sdpb_ram #(
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 8,
    parameter bit OUT_REG = 1'b0
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                wr_en_i,
    input  wire logic [ADDR_W-1:0]   wr_addr_i,
    input  wire logic [DATA_W-1:0]   wr_data_i,
    input  wire logic [DATA_W/8-1:0] wr_be_i,
    input  wire logic                rd_en_i,
    input  wire logic [ADDR_W-1:0]   rd_addr_i,
    output logic      [DATA_W-1:0]   rd_data_o
);
    localparam int BE_W  = DATA_W / 8;
    localparam int WORDS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:WORDS-1];
    logic [DATA_W-1:0] rd_stage1_q;

    // Write port: no reset, contents survive a logic reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be_i[b]) begin
                    mem[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

    // Registered read; only loads on a read so the word is held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_stage1_q <= '0;
        end else if (rd_en_i) begin
            rd_stage1_q <= mem[rd_addr_i];
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic              rd_en_q;
            logic [DATA_W-1:0] rd_stage2_q;

            // Output register captures only words that were actually read
            // the previous cycle, so it too holds between reads.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_en_q     <= 1'b0;
                    rd_stage2_q <= '0;
                end else begin
                    rd_en_q <= rd_en_i;
                    if (rd_en_q) begin
                        rd_stage2_q <= rd_stage1_q;
                    end
                end
            end

            assign rd_data_o = rd_stage2_q;
        end else begin : g_no_out_reg
            assign rd_data_o = rd_stage1_q;
        end
    endgenerate

endmodule : sdpb_ram
`default_nettype wire

// File: rtl/sdpb_bank_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sdpb_bank_buffer
//  Description : Multi-bank (ping-pong and deeper) frame/line buffer. The
//                writer fills bank wr_ptr and commits it; the reader drains
//                bank rd_ptr and releases it. Banks rotate modulo NUM_BANKS.
//  Ports       : clk, reset - clock, synchronous active-high reset
//                bus        - sdpb_bank_buffer_if.slave handshake bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module sdpb_bank_buffer
    import sdpb_pkg::*;
#(
    parameter int DATA_W       = 128,
    parameter int DEPTH        = 128,
    parameter int NUM_BANKS    = 2,
    parameter int READ_LATENCY = RL_BYPASS
) (
    input  wire logic         clk,
    input  wire logic         reset,
    sdpb_bank_buffer_if.slave bus
);
    localparam int ADDR_W = clog2(DEPTH);
    localparam int BANK_W = clog2(NUM_BANKS);
    localparam int CNT_W  = BANK_W + 1;
    localparam int RAM_AW = BANK_W + ADDR_W;
    localparam bit OUT_REG = (READ_LATENCY == RL_PIPE);

    localparam logic [SDPB_PTR_W-1:0] C_PTR_MASK = SDPB_PTR_W'(NUM_BANKS - 1);
    localparam logic [SDPB_PTR_W-1:0] C_PTR_ONE  = SDPB_PTR_W'(1);
    localparam logic [SDPB_CNT_W-1:0] C_CNT_ONE  = SDPB_CNT_W'(1);
    localparam logic [SDPB_CNT_W-1:0] C_CNT_FULL = SDPB_CNT_W'(NUM_BANKS);

    bank_state_t state_q, state_d;
    logic        wr_ready_q, wr_ready_d;
    logic        rd_avail_q, rd_avail_d;
    logic        wr_drop_q,  wr_drop_d;

    logic        w_wr_acc;
    logic        w_commit_acc;
    logic        w_release_acc;
    logic        w_rd_acc;
    logic        w_rd_dvalid;
    logic [DATA_W-1:0] w_rd_data;

    // Acceptance always uses the pre-edge flags, so a release in the same
    // cycle cannot rescue a commit into a full buffer.
    assign w_wr_acc      = bus.wr_en      & wr_ready_q;
    assign w_commit_acc  = bus.wr_commit  & wr_ready_q;
    assign w_release_acc = bus.rd_release & rd_avail_q;
    assign w_rd_acc      = bus.rd_en      & rd_avail_q;

    always_comb begin
        state_d   = state_q;
        wr_drop_d = (bus.wr_en | bus.wr_commit) & ~wr_ready_q;

        if (w_commit_acc) begin
            state_d.wr_ptr = (state_q.wr_ptr + C_PTR_ONE) & C_PTR_MASK;
        end
        if (w_release_acc) begin
            state_d.rd_ptr = (state_q.rd_ptr + C_PTR_ONE) & C_PTR_MASK;
        end
        case ({w_commit_acc, w_release_acc})
            2'b10:   state_d.banks_full = state_q.banks_full + C_CNT_ONE;
            2'b01:   state_d.banks_full = state_q.banks_full - C_CNT_ONE;
            default: state_d.banks_full = state_q.banks_full;
        endcase

        wr_ready_d = (state_d.banks_full != C_CNT_FULL);
        rd_avail_d = (state_d.banks_full != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= '0;
            wr_ready_q <= 1'b1;
            rd_avail_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ready_q <= wr_ready_d;
            rd_avail_q <= rd_avail_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

    // Valid pipeline tracks the RAM read latency; flushed on reset so no
    // in-flight word is ever flagged valid afterwards.
    generate
        if (READ_LATENCY == RL_PIPE) begin : g_valid_pipe
            logic [1:0] rd_v_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_v_q <= '0;
                end else begin
                    rd_v_q <= {rd_v_q[0], w_rd_acc};
                end
            end
            assign w_rd_dvalid = rd_v_q[1];
        end else begin : g_valid_bypass
            logic rd_v_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_v_q <= 1'b0;
                end else begin
                    rd_v_q <= w_rd_acc;
                end
            end
            assign w_rd_dvalid = rd_v_q;
        end
    endgenerate

    // Writes only hit uncommitted banks and reads only committed ones, so
    // the two ports never collide on one address.
    sdpb_ram #(
        .DATA_W  (DATA_W),
        .ADDR_W  (RAM_AW),
        .OUT_REG (OUT_REG)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (w_wr_acc),
        .wr_addr_i ({state_q.wr_ptr[BANK_W-1:0], bus.wr_addr}),
        .wr_data_i (bus.wr_data),
        .wr_be_i   (bus.wr_be),
        .rd_en_i   (w_rd_acc),
        .rd_addr_i ({state_q.rd_ptr[BANK_W-1:0], bus.rd_addr}),
        .rd_data_o (w_rd_data)
    );

    assign bus.wr_ready   = wr_ready_q;
    assign bus.rd_avail   = rd_avail_q;
    assign bus.wr_drop    = wr_drop_q;
    assign bus.rd_dvalid  = w_rd_dvalid;
    assign bus.rd_data    = w_rd_data;
    assign bus.banks_full = state_q.banks_full[CNT_W-1:0];

endmodule : sdpb_bank_buffer
`default_nettype wire

// File: tb/tb_sdpb_bank_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdpb_bank_buffer
//  Description : Directed self-checking bench. u_dut1 uses bypass read
//                latency, u_dut2 the pipelined read latency; both are
//                128-bit x 128 words x 2 banks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdpb_bank_buffer;
    import sdpb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sdpb_bank_buffer_if #(.DATA_W(128), .DEPTH(128), .NUM_BANKS(2)) b1 ();
    sdpb_bank_buffer_if #(.DATA_W(128), .DEPTH(128), .NUM_BANKS(2)) b2 ();

    sdpb_bank_buffer #(
        .DATA_W(128), .DEPTH(128), .NUM_BANKS(2), .READ_LATENCY(RL_BYPASS)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    sdpb_bank_buffer #(
        .DATA_W(128), .DEPTH(128), .NUM_BANKS(2), .READ_LATENCY(RL_PIPE)
    ) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] C_BYTE0_CLR = {{120{1'b1}}, 8'h00};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        b1.wr_en = 1'b0; b1.wr_addr = '0; b1.wr_data = '0; b1.wr_be = '0;
        b1.wr_commit = 1'b0; b1.rd_en = 1'b0; b1.rd_addr = '0; b1.rd_release = 1'b0;
        b2.wr_en = 1'b0; b2.wr_addr = '0; b2.wr_data = '0; b2.wr_be = '0;
        b2.wr_commit = 1'b0; b2.rd_en = 1'b0; b2.rd_addr = '0; b2.rd_release = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_all();
        reset = 1'b1;
        step();
        step();
        // ---- reset state ----
        chk("rst_wr_ready",   b1.wr_ready,   1);
        chk("rst_rd_avail",   b1.rd_avail,   0);
        chk("rst_banks_full", b1.banks_full, 0);
        chk("rst_rd_dvalid",  b1.rd_dvalid,  0);
        chk("rst_rd_data",    b1.rd_data,    0);
        chk("rst_wr_drop",    b1.wr_drop,    0);
        chk("rst2_rd_data",   b2.rd_data,    0);
        chk("rst2_wr_ready",  b2.wr_ready,   1);
        reset = 1'b0;
        step();

        // ---- fill bank 0 of both DUTs with data = addr ----
        for (int a = 0; a < 128; a++) begin
            b1.wr_en = 1'b1; b1.wr_addr = 7'(a); b1.wr_data = 128'(a); b1.wr_be = '1;
            b2.wr_en = 1'b1; b2.wr_addr = 7'(a); b2.wr_data = 128'(a); b2.wr_be = '1;
            step();
        end
        idle_all();
        b1.wr_commit = 1'b1;
        b2.wr_commit = 1'b1;
        step();
        idle_all();
        chk("t1_banks_full", b1.banks_full, 1);
        chk("t1_rd_avail",   b1.rd_avail,   1);
        chk("t1_wr_ready",   b1.wr_ready,   1);
        chk("t2_banks_full", b2.banks_full, 1);

        // ---- single read, bypass latency ----
        b1.rd_en = 1'b1; b1.rd_addr = 7'd5;
        step();
        idle_all();
        chk("t1_dvalid", b1.rd_dvalid, 1);
        chk("t1_data",   b1.rd_data,   5);
        step();
        chk("t1_dvalid_low", b1.rd_dvalid, 0);
        chk("t1_data_hold",  b1.rd_data,   5);

        // ---- streaming reads, pipelined latency ----
        b2.rd_en = 1'b1; b2.rd_addr = 7'd0;
        step();
        chk("t2_lat_c1", b2.rd_dvalid, 0);
        b2.rd_addr = 7'd1;
        step();
        chk("t2_dv0", b2.rd_dvalid, 1);
        chk("t2_d0",  b2.rd_data,   0);
        b2.rd_addr = 7'd2;
        step();
        chk("t2_dv1", b2.rd_dvalid, 1);
        chk("t2_d1",  b2.rd_data,   1);
        b2.rd_addr = 7'd3;
        step();
        chk("t2_dv2", b2.rd_dvalid, 1);
        chk("t2_d2",  b2.rd_data,   2);
        idle_all();
        step();
        chk("t2_dv3", b2.rd_dvalid, 1);
        chk("t2_d3",  b2.rd_data,   3);
        step();
        chk("t2_dv_end",  b2.rd_dvalid, 0);
        chk("t2_d_hold",  b2.rd_data,   3);

        // ---- byte enables into bank 1, then fill buffer ----
        b1.wr_en = 1'b1; b1.wr_addr = 7'd3; b1.wr_data = '1; b1.wr_be = '1;
        step();
        b1.wr_data = '0; b1.wr_be = 16'h0001;
        step();
        idle_all();
        b1.wr_commit = 1'b1;
        step();
        idle_all();
        chk("t3_banks_full", b1.banks_full, 2);
        chk("t3_wr_ready",   b1.wr_ready,   0);

        // ---- writes and commits on a full buffer are dropped ----
        b1.wr_en = 1'b1; b1.wr_addr = 7'd3; b1.wr_data = 128'h1234; b1.wr_be = '1;
        step();
        idle_all();
        chk("t3_drop_wr", b1.wr_drop, 1);
        step();
        chk("t3_drop_clr", b1.wr_drop, 0);
        b1.wr_commit = 1'b1;
        step();
        idle_all();
        chk("t3_drop_commit", b1.wr_drop, 1);
        chk("t3_full_kept",   b1.banks_full, 2);

        // ---- release bank 0, read byte-enabled word from bank 1 ----
        b1.rd_release = 1'b1;
        step();
        idle_all();
        chk("t5_banks_full", b1.banks_full, 1);
        chk("t5_wr_ready",   b1.wr_ready,   1);
        b1.rd_en = 1'b1; b1.rd_addr = 7'd3;
        step();
        idle_all();
        chk("t5_dvalid", b1.rd_dvalid, 1);
        chk("t5_data",   b1.rd_data,   C_BYTE0_CLR);

        // ---- simultaneous commit + release (write and read in same cycle) ----
        b1.wr_en = 1'b1; b1.wr_addr = 7'd7; b1.wr_data = 128'hA5A5; b1.wr_be = '1;
        b1.wr_commit = 1'b1;
        b1.rd_en = 1'b1; b1.rd_addr = 7'd3; b1.rd_release = 1'b1;
        step();
        idle_all();
        chk("t4_banks_full", b1.banks_full, 1);
        chk("t4_old_bank_rd", b1.rd_data,  C_BYTE0_CLR);
        chk("t4_wr_ready",    b1.wr_ready, 1);
        b1.rd_en = 1'b1; b1.rd_addr = 7'd7;
        step();
        idle_all();
        chk("t4_new_bank_dv", b1.rd_dvalid, 1);
        chk("t4_new_bank_rd", b1.rd_data,   128'hA5A5);

        // ---- reset with reads in flight on the pipelined DUT ----
        b2.rd_en = 1'b1; b2.rd_addr = 7'd10;
        step();
        b2.rd_addr = 7'd11;
        reset = 1'b1;
        step();
        idle_all();
        chk("t6_dvalid",     b2.rd_dvalid,  0);
        chk("t6_data",       b2.rd_data,    0);
        chk("t6_banks_full", b2.banks_full, 0);
        chk("t6_wr_ready",   b2.wr_ready,   1);
        chk("t6_rd_avail",   b2.rd_avail,   0);
        reset = 1'b0;
        step();
        chk("t6_dvalid_post", b2.rd_dvalid, 0);
        // read with nothing committed is ignored
        b2.rd_en = 1'b1; b2.rd_addr = 7'd10;
        step();
        idle_all();
        step();
        chk("t6_empty_rd_dv",   b2.rd_dvalid, 0);
        chk("t6_empty_rd_data", b2.rd_data,   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_sdpb_bank_buffer
`default_nettype wire

// File: doc/sdpb_bank_buffer.md
Name: sdpb_bank_buffer

Overview:
- Parametrised multi-bank (ping-pong and deeper) frame/line buffer built on an inferred simple-dual-port RAM in a single clock domain.
- The HDMI capture side fills one bank while the matrix output side reads a previously committed bank.
- Banks are handed over with explicit commit/release handshakes. Read latency and byte-enabled writes are selectable.
- Sits between the HDMI pixel packer and the matrix SPI serializer. It replaces the fixed 128x128 dual-clock RAM wrapper.

Parameters:
DATA_W, 128, word width in bits; must be a multiple of 8.
DEPTH, 128, words per bank; must be a power of two, at least 2.
NUM_BANKS, 2, number of banks; must be a power of two, at least 2.
READ_LATENCY, 1, 1 = bypass (registered RAM output), 2 = pipelined (extra output register).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe
wr_addr  in  clog2(DEPTH)  word address within the current write bank
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte enables, bit i covers byte i
wr_commit  in  1  mark the current write bank full and advance to the next bank
wr_ready  out  1  current write bank is free
wr_drop  out  1  one-cycle pulse: wr_en or wr_commit was ignored
rd_en  in  1  read strobe
rd_addr  in  clog2(DEPTH)  word address within the current read bank
rd_release  in  1  free the current read bank and advance to the next bank
rd_avail  out  1  current read bank holds committed data
rd_data  out  DATA_W  read data
rd_dvalid  out  1  rd_data valid this cycle
banks_full  out  clog2(NUM_BANKS)+1  number of committed, unreleased banks

Behaviour:
- Reset, synchronous: wr_ptr=0, rd_ptr=0, banks_full=0, wr_ready=1, rd_avail=0, rd_dvalid=0, rd_data=0, wr_drop=0, read pipeline flushed. RAM contents are not cleared. A reset mid-operation discards all banks and any in-flight reads.
- wr_ready = (banks_full != NUM_BANKS).
- rd_avail = (banks_full != 0).
- Physical address = {bank_ptr, word_addr}, with storage NUM_BANKS*DEPTH x DATA_W.
- Write path:
  - wr_en with wr_ready: bytes with wr_be=1 are written to {wr_ptr, wr_addr}; other bytes keep their value.
  - wr_en without wr_ready: no write; wr_drop=1 next cycle.
  - wr_commit with wr_ready: wr_ptr increments modulo NUM_BANKS and banks_full increments.
  - wr_commit without wr_ready: ignored; wr_drop=1.
  - wr_en and wr_commit in the same cycle: the write lands in the old bank, then the pointer advances.
- Read path:
  - rd_en with rd_avail: reads {rd_ptr, rd_addr}. rd_data and rd_dvalid appear exactly READ_LATENCY cycles later. Back-to-back reads give one word per cycle.
  - rd_en without rd_avail: ignored; no rd_dvalid.
  - rd_data holds its last value while rd_dvalid=0.
  - rd_release with rd_avail: rd_ptr increments modulo NUM_BANKS and banks_full decrements. rd_release without rd_avail is ignored.
  - rd_en and rd_release in the same cycle: the read uses the old bank, then the pointer advances.
  - Reads already in the pipeline when release occurs still deliver data.
- Simultaneous accepted wr_commit and rd_release: both pointers advance and banks_full is unchanged. Acceptance is evaluated on pre-edge flags. A commit on a full buffer is dropped even if a release occurs in the same cycle.
- Read/write collision: writes only target non-committed banks and reads only target committed banks, so the same physical address is never read and written in one cycle. No bypass logic is required.
- Status outputs are registered and reflect the new pointer state one cycle after the event.

Decomposition:
- Package sdpb_pkg: function clog2, the READ_LATENCY encoding constants (RL_BYPASS=1, RL_PIPE=2), and a bank-state struct holding wr_ptr, rd_ptr and banks_full.
- Sub-module sdpb_ram: inferable simple-dual-port RAM.
  - Parameters: DATA_W, ADDR_W, OUT_REG.
  - Byte-enabled write, registered read, optional output register with synchronous reset.
  - Maps to Gowin SDPB primitives.
- The top level holds the bank control, handshake and valid pipeline.

Test Plan:
1. Reset, then write addr 0..127 with data=addr, all wr_be=1, commit, rd_en addr 5 (READ_LATENCY=1) -> rd_dvalid and rd_data=5 one cycle later; banks_full=1.
2. Repeat test 1 with READ_LATENCY=2, streaming reads of addr 0..3 -> rd_dvalid high for 4 consecutive cycles starting 2 cycles after the first rd_en, data 0,1,2,3.
3. NUM_BANKS=2: commit twice without release -> wr_ready=0, banks_full=2. A further wr_en produces wr_drop and leaves memory unchanged; a further wr_commit also produces wr_drop.
4. With banks_full=1, assert wr_commit and rd_release in the same cycle -> banks_full stays 1 and both pointers advance. The next read returns the newly committed bank's data.
5. Write 0xFF..FF to addr 3, then write 0 with wr_be=0x0001, commit, read addr 3 -> only byte 0 is 0x00, all other bytes 0xFF.
6. Reset asserted mid-stream while reads are in flight -> rd_dvalid=0 the next cycle, banks_full=0, wr_ready=1, rd_avail=0; stale in-flight data is never presented.
